// File: rtl/cart_loader_pkg.sv
// Shared types and constants for the cartridge loader.
package cart_loader_pkg;

  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam int unsigned IDX_W        = 8;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned PAGES_W      = 6;
  localparam int unsigned PAGE_SHIFT   = 14;

  localparam logic [15:0] COLECO_HDR_A = 16'hAA55;
  localparam logic [15:0] COLECO_HDR_B = 16'h55AA;
  localparam logic [15:0] SG_RAM_LO    = 16'h2000;
  localparam logic [15:0] SG_RAM_HI    = 16'h3FFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Committed cartridge metadata as seen by the console core.
  typedef struct packed {
    logic [PAGES_W-1:0] pages;
    logic               sg1000;
    logic               extram;
    logic               header_ok;
    logic               overflow;
    logic               valid;
  } meta_t;

  // True when the two leading image bytes form a Coleco cartridge signature.
  function automatic logic hdr_match(input logic [15:0] hdr);
    return (hdr == COLECO_HDR_A) || (hdr == COLECO_HDR_B);
  endfunction

endpackage

// File: rtl/cart_loader_if.sv
// Download stream from hps_io and SDRAM write port seen by the loader.
interface cart_loader_if #(
  parameter int unsigned ADDR_BITS = 20
);
  import cart_loader_pkg::*;

  logic                    ioctl_download;
  logic [IDX_W-1:0]        ioctl_index;
  logic                    ioctl_wr;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [DATA_W-1:0]       ioctl_dout;
  logic                    ioctl_wait;

  logic [ADDR_BITS-1:0]    mem_addr;
  logic [DATA_W-1:0]       mem_din;
  logic                    mem_we;
  logic                    mem_ready;

  // Environment side: hps_io download source plus SDRAM acceptor.
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
    input  ioctl_wait, mem_addr, mem_din, mem_we
  );

  // Loader side.
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
    output ioctl_wait, mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/cart_meta_tracker.sv
// Shadows cartridge metadata while a download runs and commits it at the end.
module cart_meta_tracker
  import cart_loader_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 20
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sg_sel,
  input  logic                 accept,
  input  logic                 drop,
  input  logic                 commit,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    data,
  output meta_t                meta
);

  localparam int unsigned CNT_W = ADDR_BITS + 1;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] last_q, last_d;
  logic                 ff_run_q, ff_run_d;
  logic [DATA_W-1:0]    hdr0_q, hdr0_d;
  logic [DATA_W-1:0]    hdr1_q, hdr1_d;
  logic                 hdr0_got_q, hdr0_got_d;
  logic                 hdr1_got_q, hdr1_got_d;
  logic                 ovf_q, ovf_d;
  logic                 sg_q, sg_d;
  meta_t                meta_q, meta_d;

  logic in_ram_c;
  logic ext_cover_c;

  assign in_ram_c    = (32'(addr) >= 32'(SG_RAM_LO)) && (32'(addr) <= 32'(SG_RAM_HI));
  assign ext_cover_c = 32'(last_q) >= 32'(SG_RAM_HI);

  // Shadow update on clear/accept/drop and atomic commit of the metadata.
  always_comb begin
    cnt_d      = cnt_q;
    last_d     = last_q;
    ff_run_d   = ff_run_q;
    hdr0_d     = hdr0_q;
    hdr1_d     = hdr1_q;
    hdr0_got_d = hdr0_got_q;
    hdr1_got_d = hdr1_got_q;
    ovf_d      = ovf_q;
    sg_d       = sg_q;
    meta_d     = meta_q;

    if (start) begin
      cnt_d        = '0;
      last_d       = '0;
      ff_run_d     = 1'b1;
      hdr0_d       = '0;
      hdr1_d       = '0;
      hdr0_got_d   = 1'b0;
      hdr1_got_d   = 1'b0;
      ovf_d        = 1'b0;
      sg_d         = sg_sel;
      meta_d.valid = 1'b0;
    end

    if (accept) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      last_d = addr;
      if (addr == ADDR_BITS'(0)) begin
        hdr0_d     = data;
        hdr0_got_d = 1'b1;
      end
      if (addr == ADDR_BITS'(1)) begin
        hdr1_d     = data;
        hdr1_got_d = 1'b1;
      end
      if (in_ram_c && (data != 8'hFF)) begin
        ff_run_d = 1'b0;
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end

    if (commit) begin
      meta_d.pages     = PAGES_W'(last_q >> PAGE_SHIFT);
      meta_d.sg1000    = sg_q;
      meta_d.extram    = sg_q & ff_run_q & ext_cover_c;
      meta_d.header_ok = ~sg_q & hdr0_got_q & hdr1_got_q & hdr_match({hdr0_q, hdr1_q});
      meta_d.overflow  = ovf_q;
      meta_d.valid     = (cnt_q != '0);
    end
  end

  // Shadow and committed-metadata registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      last_q     <= '0;
      ff_run_q   <= 1'b0;
      hdr0_q     <= '0;
      hdr1_q     <= '0;
      hdr0_got_q <= 1'b0;
      hdr1_got_q <= 1'b0;
      ovf_q      <= 1'b0;
      sg_q       <= 1'b0;
      meta_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      ff_run_q   <= ff_run_d;
      hdr0_q     <= hdr0_d;
      hdr1_q     <= hdr1_d;
      hdr0_got_q <= hdr0_got_d;
      hdr1_got_q <= hdr1_got_d;
      ovf_q      <= ovf_d;
      sg_q       <= sg_d;
      meta_q     <= meta_d;
    end
  end

  assign meta = meta_q;

endmodule

// File: rtl/cart_loader.sv
// Moves hps_io download bytes into cartridge SDRAM and publishes cart metadata.
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 20,
  parameter logic [4:0]  SG_INDEX       = 5'd2,
  parameter logic [4:0]  ROM_INDEX_MASK = 5'h1F
) (
  input  logic               clk_sys,
  input  logic               reset,
  cart_loader_if.slave       bus,
  output logic [PAGES_W-1:0] cart_pages,
  output logic               sg1000,
  output logic               extram,
  output logic               header_ok,
  output logic               overflow,
  output logic               cart_valid
);

  state_e state_q, state_d;

  logic                 dl_q, dl_d;
  logic                 mem_we_q, mem_we_d;
  logic                 wait_q, wait_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    din_q, din_d;

  logic  start_c;
  logic  accept_c;
  logic  drop_c;
  logic  commit_c;
  logic  in_range_c;
  logic  sg_sel_c;
  meta_t meta;

  assign in_range_c = (bus.ioctl_addr >> ADDR_BITS) == IOCTL_ADDR_W'(0);
  assign sg_sel_c   = (bus.ioctl_index & {3'b000, ROM_INDEX_MASK}) == {3'b000, SG_INDEX};

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a pending write always finishes before FINISH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.ioctl_download && !dl_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!bus.ioctl_download) begin
          state_d = FINISH;
        end else if (bus.ioctl_wr && in_range_c) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          state_d = LOAD;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output/datapath logic: byte latch, write request, backpressure, tracker strobes.
  always_comb begin
    dl_d     = bus.ioctl_download;
    mem_we_d = mem_we_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    din_d    = din_q;
    start_c  = 1'b0;
    accept_c = 1'b0;
    drop_c   = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        start_c = bus.ioctl_download && !dl_q;
      end
      LOAD: begin
        if (bus.ioctl_download && bus.ioctl_wr) begin
          if (in_range_c) begin
            accept_c = 1'b1;
            addr_d   = ADDR_BITS'(bus.ioctl_addr);
            din_d    = bus.ioctl_dout;
            mem_we_d = 1'b1;
            wait_d   = 1'b1;
          end else begin
            drop_c = 1'b1;
          end
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          mem_we_d = 1'b0;
          wait_d   = 1'b0;
        end
      end
      FINISH: begin
        commit_c = 1'b1;
      end
      default: begin
        mem_we_d = 1'b0;
        wait_d   = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops the write request and backpressure at once.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q     <= 1'b0;
      mem_we_q <= 1'b0;
      wait_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      dl_q     <= dl_d;
      mem_we_q <= mem_we_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  cart_meta_tracker #(
    .ADDR_BITS (ADDR_BITS)
  ) u_meta (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (start_c),
    .sg_sel  (sg_sel_c),
    .accept  (accept_c),
    .drop    (drop_c),
    .commit  (commit_c),
    .addr    (ADDR_BITS'(bus.ioctl_addr)),
    .data    (bus.ioctl_dout),
    .meta    (meta)
  );

  assign bus.ioctl_wait = wait_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_din    = din_q;

  assign cart_pages = meta.pages;
  assign sg1000     = meta.sg1000;
  assign extram     = meta.extram;
  assign header_ok  = meta.header_ok;
  assign overflow   = meta.overflow;
  assign cart_valid = meta.valid;

endmodule

// File: tb/tb_cart_loader.sv
// Randomized self-checking bench for cart_loader against a byte-list reference model.
module tb_cart_loader;

  localparam int unsigned AB    = 20;
  localparam int unsigned LIMIT = 32'h100000;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  cart_loader_if #(.ADDR_BITS(AB)) bus ();

  logic [5:0] cart_pages;
  logic       sg1000, extram, header_ok, overflow, cart_valid;

  cart_loader #(
    .ADDR_BITS      (AB),
    .SG_INDEX       (5'd2),
    .ROM_INDEX_MASK (5'h1F)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .cart_pages (cart_pages),
    .sg1000     (sg1000),
    .extram     (extram),
    .header_ok  (header_ok),
    .overflow   (overflow),
    .cart_valid (cart_valid)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [19:0] a;
    logic [7:0]  d;
  } wr_t;

  int unsigned st_addr[$];
  logic [7:0]  st_data[$];
  wr_t         got_wr[$];
  int          rdy_dly = 0;
  logic [9:0]  prev_meta = '0;

  // SDRAM acceptor: answers each request after rdy_dly extra cycles, checks hold and wait.
  initial begin : sdram
    int         age;
    logic [19:0] a0;
    logic [7:0]  d0;
    age = 0;
    a0 = '0;
    d0 = '0;
    bus.mem_ready = 1'b0;
    forever begin
      @(negedge clk_sys);
      bus.mem_ready = 1'b0;
      if (reset) begin
        age = 0;
      end else begin
        check("wait_tracks_we", bus.ioctl_wait, bus.mem_we);
        if (bus.mem_we) begin
          if (age == 0) begin
            a0 = bus.mem_addr;
            d0 = bus.mem_din;
          end
          if (age >= rdy_dly) begin
            check("we_hold", {bus.mem_addr, bus.mem_din}, {a0, d0});
            got_wr.push_back('{a: bus.mem_addr, d: bus.mem_din});
            bus.mem_ready = 1'b1;
            age = 0;
          end else begin
            age++;
          end
        end
      end
    end
  end

  task automatic wait_no_wait();
    for (int i = 0; i < 64 && bus.ioctl_wait; i++) @(negedge clk_sys);
    if (bus.ioctl_wait) check("wait_timeout", 1, 0);
  endtask

  task automatic send_byte(input int unsigned a, input logic [7:0] d);
    wait_no_wait();
    bus.ioctl_addr = 25'(a);
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    check("wr_to_we", bus.mem_we, (a < LIMIT) ? 1 : 0);
    repeat ($urandom_range(0, 2)) @(negedge clk_sys);
  endtask

  task automatic clear_img();
    st_addr.delete();
    st_data.delete();
  endtask

  task automatic add(input int unsigned a, input logic [7:0] d);
    st_addr.push_back(a);
    st_data.push_back(d);
  endtask

  // Reference: metadata derived directly from the list of bytes offered to the loader.
  task automatic model(input logic [7:0] idx, output logic [9:0] m, output logic v);
    bit          sg, ff, ovf, h0, h1;
    logic [7:0]  b0, b1;
    int unsigned last;
    int          n;
    bit          ext, hdr;
    sg = ((idx & 8'h1F) == 8'h02);
    ff = 1; ovf = 0; h0 = 0; h1 = 0; b0 = 0; b1 = 0; last = 0; n = 0;
    foreach (st_addr[i]) begin
      if (st_addr[i] >= LIMIT) begin
        ovf = 1;
      end else begin
        n++;
        last = st_addr[i];
        if (st_addr[i] == 0) begin h0 = 1; b0 = st_data[i]; end
        if (st_addr[i] == 1) begin h1 = 1; b1 = st_data[i]; end
        if (st_addr[i] >= 32'h2000 && st_addr[i] <= 32'h3FFF && st_data[i] != 8'hFF) ff = 0;
      end
    end
    ext = sg && ff && (last >= 32'h3FFF);
    hdr = !sg && h0 && h1 && ((b0 == 8'hAA && b1 == 8'h55) || (b0 == 8'h55 && b1 == 8'hAA));
    m = {6'((last / 16384) % 64), sg, ext, hdr, ovf};
    v = (n != 0);
  endtask

  task automatic run_image(input logic [7:0] idx, input int dly, input bit early);
    logic [9:0] em;
    logic       ev;
    int         k;
    got_wr.delete();
    rdy_dly = dly;
    @(negedge clk_sys);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("valid_clr", cart_valid, 0);
    check("hold_start", {cart_pages, sg1000, extram, header_ok, overflow}, prev_meta);
    @(negedge clk_sys);
    foreach (st_addr[i]) send_byte(st_addr[i], st_data[i]);
    if (early) check("early_pending", bus.mem_we, 1);
    else wait_no_wait();
    bus.ioctl_download = 1'b0;
    if (early) wait_no_wait();
    @(negedge clk_sys);
    check("hold_finish", {cart_pages, sg1000, extram, header_ok, overflow, cart_valid},
          {prev_meta, 1'b0});
    @(negedge clk_sys);
    model(idx, em, ev);
    check("cart_pages", cart_pages, em[9:4]);
    check("sg1000", sg1000, em[3]);
    check("extram", extram, em[2]);
    check("header_ok", header_ok, em[1]);
    check("overflow", overflow, em[0]);
    check("cart_valid", cart_valid, ev);
    k = 0;
    foreach (st_addr[i]) begin
      if (st_addr[i] < LIMIT) begin
        if (k < got_wr.size())
          check("wr_order", {got_wr[k].a, got_wr[k].d}, {20'(st_addr[i]), st_data[i]});
        k++;
      end
    end
    check("wr_count", got_wr.size(), k);
    prev_meta = em;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] idx;
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = '0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_out", {cart_pages, sg1000, extram, header_ok, overflow, cart_valid}, 0);
    check("rst_bus", {bus.mem_we, bus.ioctl_wait}, 0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Coleco image, contiguous, AA 55 header.
    clear_img();
    add(0, 8'hAA);
    add(1, 8'h55);
    for (int a = 2; a < 512; a++) add(a, 8'($urandom));
    run_image(8'h00, 2, 0);

    // SG-1000 image with 2000-3FFF all FF, ending at 7FFF.
    for (int pass = 0; pass < 2; pass++) begin
      clear_img();
      for (int a = 0; a < 8; a++) add(a, 8'($urandom));
      add(32'h2000, 8'hFF);
      for (int i = 0; i < 40; i++) add($urandom_range(32'h2000, 32'h3FFF), 8'hFF);
      if (pass == 1) add(32'h2A00, 8'h00);
      add(32'h3FFF, 8'hFF);
      for (int i = 0; i < 10; i++) add($urandom_range(32'h4000, 32'h7FFE), 8'($urandom));
      add(32'h7FFF, 8'h5A);
      run_image(8'h22, 0, 0);
    end

    // SG image ending at 2FFF: RAM window not fully covered.
    clear_img();
    add(0, 8'hF3);
    for (int i = 0; i < 30; i++) add($urandom_range(32'h2000, 32'h2FFE), 8'hFF);
    add(32'h2FFF, 8'hFF);
    run_image(8'h02, 1, 0);

    // Download drops while the last write is still pending.
    clear_img();
    add(0, 8'h55);
    add(1, 8'hAA);
    for (int a = 2; a < 20; a++) add(a, 8'($urandom));
    run_image(8'h40, 10, 1);

    // Out-of-range bytes are dropped and flagged.
    clear_img();
    add(0, 8'hAA);
    add(1, 8'h55);
    add(32'h100000, 8'h12);
    add(5, 8'h34);
    add(32'h1FFFFFF, 8'h56);
    run_image(8'h00, 1, 0);

    // Zero-byte download.
    clear_img();
    run_image(8'h02, 0, 0);

    // Random images.
    repeat (5) begin
      clear_img();
      idx = 8'($urandom);
      if ($urandom_range(0, 1) == 1) idx = {3'($urandom), 5'd2};
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
        case ($urandom_range(0, 4))
          0: add($urandom_range(0, 1), ($urandom_range(0, 1) == 1) ? 8'hAA : 8'h55);
          1: add($urandom_range(32'h2000, 32'h3FFF),
                 ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hFF);
          2: add($urandom_range(0, 32'hFFFFF), 8'($urandom));
          3: add($urandom_range(32'h100000, 32'h1FFFFFF), 8'($urandom));
          default: add($urandom_range(32'h3FFF, 32'h7FFF), 8'hFF);
        endcase
      end
      run_image(idx, $urandom_range(0, 3), 0);
    end

    // Reset while a write is pending, then a normal download.
    clear_img();
    got_wr.delete();
    rdy_dly = 20;
    @(negedge clk_sys);
    bus.ioctl_index    = 8'h02;
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    send_byte(32'h10, 8'h77);
    check("pre_rst_we", bus.mem_we, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_bus", {bus.mem_we, bus.ioctl_wait}, 0);
    check("rst_mid_out", {cart_pages, sg1000, extram, header_ok, overflow, cart_valid}, 0);
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    prev_meta = '0;
    @(negedge clk_sys);
    check("rst_no_write", got_wr.size(), 0);
    clear_img();
    add(0, 8'h55);
    add(1, 8'hAA);
    add(32'h4123, 8'h9C);
    run_image(8'h01, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
